fp_addsub_sched: RTL and testbench
==================================

Name: fp_addsub_sched

Overview:
- Shares one 32-bit IEEE-754 single-precision add/sub unit (`add_sub`: A, B, addsub, out, exception) between two requesters.
- Arbitrates round-robin and issues at most one operation per cycle.
- Tracks in-flight operations through the unit's fixed latency and routes each result and exception back to its originator.
- Sits between the unit and its clients, e.g. a dot-product sequencer and a host register port.

Parameters:
- FU_LATENCY, 1: clock edges from the cycle fu_a/fu_b/fu_addsub are driven to the edge at which fu_out/fu_exception are valid to sample (range 1..8).
- MAX_OUT, 4: maximum outstanding operations per requester (range 1..15).

Ports:
- control  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset: the block is in reset while reset==0.
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 operation accepted this cycle (valid&&ready).
- r0_a  input  32  operand A, FP32.
- r0_b  input  32  operand B, FP32.
- r0_op  input  1  0 = A+B, 1 = A-B.
- r1_valid, r1_ready, r1_a, r1_b, r1_op: same as r0 for requester 1.
- fu_a  output  32  operand A to the unit.
- fu_b  output  32  operand B to the unit.
- fu_addsub  output  1  op to the unit.
- fu_out  input  32  unit result.
- fu_exception  input  1  unit exception flag.
- resp_valid  output  2  one-hot result strobe; bit i = result for requester i.
- resp_out  output  32  registered result.
- resp_exception  output  1  registered exception.
- busy  output  1  any operation in flight.

Behaviour:
- Reset (asynchronous, reset==0): the following go to 0:
  - fu_a, fu_b, fu_addsub, resp_valid, resp_out, resp_exception, busy
  - all in-flight slots
  - both outstanding counters
  - the round-robin pointer, so requester 0 has priority first
- Reset mid-operation: all in-flight operations are discarded and none produce resp_valid after release. The unit's own pipeline contents are ignored because all slot valids are cleared.
- Eligibility: elig_i = ri_valid && cnt_i < MAX_OUT.
- Grant (combinational): ri_ready = elig_i && (!elig_j || ptr==i).
  - At most one ready per cycle.
  - ready never asserts without valid.
- Pointer: on every accepted transfer, ptr <= index of the other requester. With no accept, ptr holds.
- Issue: on the accept edge N, fu_a/fu_b/fu_addsub <= the granted requester's operands. They hold their previous values when idle.
- Tracking: a shift register of depth FU_LATENCY holds {valid, tag}.
  - Slot 0 is loaded at edge N with {1, granted index}, or {0, x} when idle.
  - Slots shift one position per edge.
- Retire: when the last slot is valid at edge N+FU_LATENCY, then at edge N+FU_LATENCY+1:
  - resp_out <= fu_out
  - resp_exception <= fu_exception
  - resp_valid[tag] <= 1
- Otherwise resp_valid <= 0, and resp_out/resp_exception hold.
- Total latency: accept edge to resp_valid high = FU_LATENCY+1 edges, so 2 at default. resp_valid is a one-cycle pulse.
- No response backpressure: requesters must consume the pulse.
- Counters (4-bit): cnt_i increments on accept and decrements on retire of tag i.
  - Simultaneous accept and retire for the same i leaves cnt_i unchanged.
  - Saturation at MAX_OUT is enforced by elig_i; the counter never wraps.
- Throughput: back-to-back issue every cycle; results return in issue order.
- busy = OR of slot valids OR any resp pending (registered).
- Operands are passed unmodified. NaN/Inf/denormal handling belongs entirely to the unit.

Decomposition:
- Shared package `fp_pkg`:
  - FP32 width constant (32)
  - op encodings OP_ADD=0, OP_SUB=1
  - requester count NUM_REQ=2
  - tag width
- One natural sub-module: `rr_arb2` (two-input round-robin grant with pointer register).
- The in-flight shift register and counters stay in the top level.
- The `add_sub` unit is instantiated outside this block, in the integrating module.

Test Plan:
- Single r0 add, A=3E800000, B=42C80000, op=0 -> r0_ready in same cycle; resp_valid=01 two edges later with resp_out=42C88000 (0.25+100), exc=0.
- r0 and r1 valid together: r0 {3FA00000+40200000}, r1 {42C80000+43C80000}.
  - First cycle grants r0, next cycle grants r1.
  - Responses are resp_valid=01 with 40700000, then 10 with 43FA0000 on consecutive cycles.
- Subtract on r1: A=42C80000, B=3E800000, op=1 -> resp_valid=10, resp_out=42C78000 (99.75).
- Outstanding limit: MAX_OUT=2, r0 held valid with A=B=3FA00000, FU_LATENCY=3.
  - r0_ready drops after 2 accepts and reasserts in the cycle after the first retire.
  - Every response is 40200000.
- Continuous r0 and r1 requests for 10 cycles -> grants alternate strictly 0,1,0,1; the total response count equals the accepts.
- Drive reset low asynchronously with 2 operations in flight -> all outputs go to 0 immediately; after release no resp_valid appears, and the first new request is granted to r0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the FP add/sub scheduler.
// Covers operand width, op encodings, requester tags and in-flight slots.
package fp_pkg;

  localparam int FP_W    = 32;
  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 1;
  localparam int CNT_W   = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/fp_addsub_sched_rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// The pointer moves to the other requester after every grant.
module rr_arb2
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_elig,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt    = '0;
    o_gnt[0] = i_elig[0] && (!i_elig[1] || !r_ptr);
    o_gnt[1] = i_elig[1] && (!i_elig[0] || r_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one FP32 add/sub unit between two requesters, tracking
// in-flight ops through the unit latency and routing results back.
module fp_addsub_sched
  import fp_pkg::*;
#(
  parameter int FU_LATENCY = 1,
  parameter int MAX_OUT    = 4
) (
  input  logic               control,
  input  logic               reset,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [FP_W-1:0]    r0_a,
  input  logic [FP_W-1:0]    r0_b,
  input  logic               r0_op,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [FP_W-1:0]    r1_a,
  input  logic [FP_W-1:0]    r1_b,
  input  logic               r1_op,
  output logic [FP_W-1:0]    fu_a,
  output logic [FP_W-1:0]    fu_b,
  output logic               fu_addsub,
  input  logic [FP_W-1:0]    fu_out,
  input  logic               fu_exception,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic [FP_W-1:0]    resp_out,
  output logic               resp_exception,
  output logic               busy
);

  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  slot_t              r_slot [FU_LATENCY];
  slot_t              r_ret;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_ret;
  logic               w_acc;
  logic [TAG_W-1:0]   w_tag;

  always_comb begin
    w_elig    = '0;
    w_elig[0] = r0_valid && (r_cnt[0] < CNT_W'(MAX_OUT));
    w_elig[1] = r1_valid && (r_cnt[1] < CNT_W'(MAX_OUT));
  end

  rr_arb2 u_arb (
    .clk    (control),
    .rst_n  (reset),
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );

  assign r0_ready = w_gnt[0];
  assign r1_ready = w_gnt[1];
  assign w_acc    = |w_gnt;
  assign w_tag    = w_gnt[1];

  always_comb begin
    w_ret = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ret[i] = r_ret.v && (r_ret.tag == TAG_W'(i));
    end
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      fu_a      <= '0;
      fu_b      <= '0;
      fu_addsub <= 1'b0;
    end else begin
      unique case (1'b1)
        w_gnt[0]: begin
          fu_a      <= r0_a;
          fu_b      <= r0_b;
          fu_addsub <= r0_op;
        end
        w_gnt[1]: begin
          fu_a      <= r1_a;
          fu_b      <= r1_b;
          fu_addsub <= r1_op;
        end
        default: ;
      endcase
    end
  end

  // Slot chain mirrors the unit pipeline; r_ret is the retire stage.
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FU_LATENCY; k++) r_slot[k] <= '0;
      r_ret <= '0;
    end else begin
      r_slot[0] <= '{v: w_acc, tag: w_tag};
      for (int k = 1; k < FU_LATENCY; k++) r_slot[k] <= r_slot[k-1];
      r_ret <= r_slot[FU_LATENCY-1];
    end
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      resp_valid     <= '0;
      resp_out       <= '0;
      resp_exception <= 1'b0;
    end else begin
      resp_valid <= w_ret;
      if (r_ret.v) begin
        resp_out       <= fu_out;
        resp_exception <= fu_exception;
      end
    end
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        unique case ({w_gnt[i], w_ret[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy = r_ret.v;
    for (int k = 0; k < FU_LATENCY; k++) busy = busy | r_slot[k].v;
  end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched with a behavioural FP unit
// modelled as a lookup of hand-computed results behind a delay pipe.
module tb_fp_addsub_sched;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance (latency 1, 4 outstanding)
  logic        a0_v, a0_rdy, a0_op, a1_v, a1_rdy, a1_op;
  logic [31:0] a0_a, a0_b, a1_a, a1_b;
  logic [31:0] afu_a, afu_b, afu_out, a_rout;
  logic        afu_op, afu_exc, a_rexc, a_busy;
  logic [1:0]  a_rv;

  // limit instance (latency 3, 2 outstanding), requester 1 idle
  logic        b0_v, b0_rdy, b1_rdy;
  logic [31:0] b0_a, b0_b;
  logic [31:0] bfu_a, bfu_b, bfu_out, b_rout;
  logic        bfu_op, bfu_exc, b_rexc, b_busy;
  logic [1:0]  b_rv;

  fp_addsub_sched u_a (
    .control(clk), .reset(rst_n),
    .r0_valid(a0_v), .r0_ready(a0_rdy), .r0_a(a0_a), .r0_b(a0_b), .r0_op(a0_op),
    .r1_valid(a1_v), .r1_ready(a1_rdy), .r1_a(a1_a), .r1_b(a1_b), .r1_op(a1_op),
    .fu_a(afu_a), .fu_b(afu_b), .fu_addsub(afu_op),
    .fu_out(afu_out), .fu_exception(afu_exc),
    .resp_valid(a_rv), .resp_out(a_rout), .resp_exception(a_rexc), .busy(a_busy)
  );

  fp_addsub_sched #(.FU_LATENCY(3), .MAX_OUT(2)) u_b (
    .control(clk), .reset(rst_n),
    .r0_valid(b0_v), .r0_ready(b0_rdy), .r0_a(b0_a), .r0_b(b0_b), .r0_op(OP_ADD),
    .r1_valid(1'b0), .r1_ready(b1_rdy), .r1_a(32'h0), .r1_b(32'h0), .r1_op(OP_ADD),
    .fu_a(bfu_a), .fu_b(bfu_b), .fu_addsub(bfu_op),
    .fu_out(bfu_out), .fu_exception(bfu_exc),
    .resp_valid(b_rv), .resp_out(b_rout), .resp_exception(b_rexc), .busy(b_busy)
  );

  function automatic logic [32:0] fp_ref(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic op);
    logic [32:0] r;
    r = {1'b0, a[31:16], b[15:0]} ^ 33'h1;
    if (a == 32'h3E800000 && b == 32'h42C80000 && op == OP_ADD) r = {1'b0, 32'h42C88000};
    if (a == 32'h3FA00000 && b == 32'h40200000 && op == OP_ADD) r = {1'b0, 32'h40700000};
    if (a == 32'h42C80000 && b == 32'h43C80000 && op == OP_ADD) r = {1'b0, 32'h43FA0000};
    if (a == 32'h42C80000 && b == 32'h3E800000 && op == OP_SUB) r = {1'b0, 32'h42C78000};
    if (a == 32'h3FA00000 && b == 32'h3FA00000 && op == OP_ADD) r = {1'b0, 32'h40200000};
    if (a == 32'h7F800000 && b == 32'hFF800000 && op == OP_ADD) r = {1'b1, 32'h7FC00000};
    return r;
  endfunction

  logic [32:0] pa [1];
  logic [32:0] pb [3];
  always_ff @(posedge clk) begin
    pa[0] <= fp_ref(afu_a, afu_b, afu_op);
    pb[0] <= fp_ref(bfu_a, bfu_b, bfu_op);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign afu_out = pa[0][31:0];
  assign afu_exc = pa[0][32];
  assign bfu_out = pb[2][31:0];
  assign bfu_exc = pb[2][32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          nresp;
  logic        e1;
  logic [13:0] b_rdy_pat;
  logic [1:0]  b_rv_exp;

  initial begin
    {a0_v, a1_v, b0_v, a0_op, a1_op} = '0;
    {a0_a, a0_b, a1_a, a1_b, b0_a, b0_b} = '0;
    #2;
    chk("rst_rv", {30'b0, a_rv}, 32'h0);
    chk("rst_out", a_rout, 32'h0);
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_fua", afu_a, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single r0 add: 0.25 + 100
    a0_v = 1'b1; a0_a = 32'h3E800000; a0_b = 32'h42C80000; a0_op = OP_ADD;
    #1;
    chk("add_rdy", {31'b0, a0_rdy}, 32'h1);
    tick();
    a0_v = 1'b0;
    chk("add_fua", afu_a, 32'h3E800000);
    chk("add_rv_n1", {30'b0, a_rv}, 32'h0);
    chk("add_busy", {31'b0, a_busy}, 32'h1);
    tick();
    chk("add_rv_n2", {30'b0, a_rv}, 32'h0);
    tick();
    chk("add_rv", {30'b0, a_rv}, 32'h1);
    chk("add_out", a_rout, 32'h42C88000);
    chk("add_exc", {31'b0, a_rexc}, 32'h0);
    tick();
    chk("add_pulse", {30'b0, a_rv}, 32'h0);

    // r1 subtract: 100 - 0.25
    a1_v = 1'b1; a1_a = 32'h42C80000; a1_b = 32'h3E800000; a1_op = OP_SUB;
    #1;
    chk("sub_rdy1", {31'b0, a1_rdy}, 32'h1);
    chk("sub_rdy0", {31'b0, a0_rdy}, 32'h0);
    tick();
    a1_v = 1'b0;
    tick();
    tick();
    chk("sub_rv", {30'b0, a_rv}, 32'h2);
    chk("sub_out", a_rout, 32'h42C78000);

    // simultaneous requests, r0 has priority
    a0_v = 1'b1; a0_a = 32'h3FA00000; a0_b = 32'h40200000; a0_op = OP_ADD;
    a1_v = 1'b1; a1_a = 32'h42C80000; a1_b = 32'h43C80000; a1_op = OP_ADD;
    #1;
    chk("both_rdy0", {31'b0, a0_rdy}, 32'h1);
    chk("both_rdy1", {31'b0, a1_rdy}, 32'h0);
    tick();
    a0_v = 1'b0;
    #1;
    chk("both_rdy1b", {31'b0, a1_rdy}, 32'h1);
    tick();
    a1_v = 1'b0;
    tick();
    chk("both_rv0", {30'b0, a_rv}, 32'h1);
    chk("both_out0", a_rout, 32'h40700000);
    tick();
    chk("both_rv1", {30'b0, a_rv}, 32'h2);
    chk("both_out1", a_rout, 32'h43FA0000);

    // exception routing: inf + -inf
    a0_v = 1'b1; a0_a = 32'h7F800000; a0_b = 32'hFF800000; a0_op = OP_ADD;
    tick();
    a0_v = 1'b0;
    tick();
    tick();
    chk("exc_rv", {30'b0, a_rv}, 32'h1);
    chk("exc_flag", {31'b0, a_rexc}, 32'h1);
    chk("exc_out", a_rout, 32'h7FC00000);

    // continuous requests; pointer now favours r1
    a0_v = 1'b1; a0_a = 32'h3FA00000; a0_b = 32'h40200000; a0_op = OP_ADD;
    a1_v = 1'b1; a1_a = 32'h42C80000; a1_b = 32'h43C80000; a1_op = OP_ADD;
    nresp = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 10) begin
        a0_v = 1'b0;
        a1_v = 1'b0;
      end
      #1;
      if (k < 10) begin
        e1 = (k % 2 == 0);
        chk("alt_r1", {31'b0, a1_rdy}, {31'b0, e1});
        chk("alt_r0", {31'b0, a0_rdy}, {31'b0, ~e1});
      end
      tick();
      if (a_rv[0]) chk("alt_out0", a_rout, 32'h40700000);
      if (a_rv[1]) chk("alt_out1", a_rout, 32'h43FA0000);
      nresp += int'(a_rv[0]) + int'(a_rv[1]);
    end
    chk("alt_count", nresp, 32'd10);
    chk("alt_idle", {31'b0, a_busy}, 32'h0);

    // outstanding limit on the latency-3, max-2 instance
    b0_a = 32'h3FA00000; b0_b = 32'h3FA00000;
    b_rdy_pat = 14'b00000001100011;
    for (int c = 0; c < 14; c++) begin
      b0_v = (c < 8);
      #1;
      chk("lim_rdy", {31'b0, b0_rdy}, {31'b0, b_rdy_pat[c]});
      b_rv_exp = (c == 5 || c == 6 || c == 10 || c == 11) ? 2'b01 : 2'b00;
      chk("lim_rv", {30'b0, b_rv}, {30'b0, b_rv_exp});
      if (b_rv[0]) chk("lim_out", b_rout, 32'h40200000);
      tick();
    end
    chk("lim_idle", {31'b0, b_busy}, 32'h0);

    // async reset with two ops in flight
    a0_v = 1'b1; a0_a = 32'h3FA00000; a0_b = 32'h40200000;
    a1_v = 1'b1; a1_a = 32'h42C80000; a1_b = 32'h43C80000;
    tick();
    a1_v = 1'b0;
    tick();
    a0_v = 1'b0;
    chk("pre_rst_busy", {31'b0, a_busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rv", {30'b0, a_rv}, 32'h0);
    chk("ar_out", a_rout, 32'h0);
    chk("ar_exc", {31'b0, a_rexc}, 32'h0);
    chk("ar_fua", afu_a, 32'h0);
    chk("ar_fub", afu_b, 32'h0);
    chk("ar_busy", {31'b0, a_busy}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_rv", {30'b0, a_rv}, 32'h0);
    end
    a0_v = 1'b1;
    a1_v = 1'b1;
    #1;
    chk("post_rst_r0", {31'b0, a0_rdy}, 32'h1);
    chk("post_rst_r1", {31'b0, a1_rdy}, 32'h0);
    tick();
    a0_v = 1'b0;
    a1_v = 1'b0;
    tick();
    tick();
    chk("post_rst_rv0", {30'b0, a_rv}, 32'h1);
    chk("post_rst_out", a_rout, 32'h40700000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
